// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the F/D, D/X and X/M latches and the PC register.
// It handles load-use bubbles, X-stage redirects and the multi-cycle mult/div freeze.
// The optional stall/flush performance counters are enabled by defining STALL_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 6,
  parameter int PERF_W     = 32
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [4:0]        fd_rs,
  input  logic [4:0]        fd_rt,
  input  logic              fd_uses_rt,
  input  logic [4:0]        dx_rd,
  input  logic              dx_is_load,
  input  logic              x_redirect,
  input  logic              md_start,
  input  logic              md_ready,
  output logic              pc_en,
  output logic              fd_en,
  output logic              fd_clr,
  output logic              dx_en,
  output logic              dx_clr,
  output logic              xm_en,
  output logic              xm_clr,
  output logic              md_busy,
  output logic              md_err,
  output logic [PERF_W-1:0] stall_cyc,
  output logic [PERF_W-1:0] flush_cnt
);

  typedef enum logic [0:0] {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               md_err_q, md_err_d;

  logic               timeout;
  logic               conflict;
  logic               md_stall;
  logic               redirect_ok;
  logic               load_use;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    sat_inc_cnt = (&v) ? v : v + CNT_W'(1);
  endfunction

  // Hazard detection
  always_comb begin
    timeout     = (state_q == BUSY) && (cnt_q == CNT_W'(MD_TIMEOUT - 1));
    conflict    = md_start & x_redirect;
    md_stall    = ((state_q == IDLE) & md_start & ~md_ready) |
                  ((state_q == BUSY) & ~md_ready & ~timeout);
    // A redirect arriving together with md_start is a protocol error and is dropped.
    redirect_ok = x_redirect & ~md_start & ~md_stall;
    load_use    = dx_is_load & (dx_rd != 5'd0) &
                  ((dx_rd == fd_rs) | (fd_uses_rt & (dx_rd == fd_rt)));
  end

  // Latch control: MD stall > redirect > load-use > normal flow
  always_comb begin
    pc_en   = 1'b1;
    fd_en   = 1'b1;
    fd_clr  = 1'b0;
    dx_en   = 1'b1;
    dx_clr  = 1'b0;
    xm_en   = 1'b1;
    xm_clr  = 1'b0;
    md_busy = 1'b0;
    if (md_stall) begin
      pc_en   = 1'b0;
      fd_en   = 1'b0;
      dx_en   = 1'b0;
      xm_clr  = 1'b1;
      md_busy = 1'b1;
    end else if (redirect_ok) begin
      fd_clr = 1'b1;
      dx_clr = 1'b1;
    end else if (load_use) begin
      pc_en  = 1'b0;
      fd_en  = 1'b0;
      dx_clr = 1'b1;
    end
    if (!clr_n) begin
      pc_en   = 1'b0;
      fd_en   = 1'b0;
      fd_clr  = 1'b1;
      dx_en   = 1'b0;
      dx_clr  = 1'b1;
      xm_en   = 1'b0;
      xm_clr  = 1'b1;
      md_busy = 1'b0;
    end
  end

  // Mult/div FSM next state
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    md_err_d = md_err_q | conflict;
    case (state_q)
      IDLE: begin
        if (md_start && !md_ready) state_d = BUSY;
      end
      BUSY: begin
        if (md_ready) begin
          state_d = IDLE;
        end else if (timeout) begin
          state_d  = IDLE;
          md_err_d = 1'b1;
        end else begin
          cnt_d = sat_inc_cnt(cnt_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      md_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      md_err_q <= md_err_d;
    end
  end

  assign md_err = md_err_q;

`ifdef STALL_PERF_EN
  logic [PERF_W-1:0] stall_cyc_q, stall_cyc_d;
  logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

  function automatic logic [PERF_W-1:0] sat_inc_perf(input logic [PERF_W-1:0] v);
    sat_inc_perf = (&v) ? v : v + PERF_W'(1);
  endfunction

  always_comb begin
    stall_cyc_d = pc_en ? stall_cyc_q : sat_inc_perf(stall_cyc_q);
    flush_cnt_d = redirect_ok ? sat_inc_perf(flush_cnt_q) : flush_cnt_q;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      stall_cyc_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cyc_q <= stall_cyc_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cyc = stall_cyc_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cyc = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; perf counter expectations follow STALL_PERF_EN.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [4:0]  fd_rs, fd_rt, dx_rd;
  logic        fd_uses_rt, dx_is_load, x_redirect, md_start, md_ready;
  logic        pc_en, fd_en, fd_clr, dx_en, dx_clr, xm_en, xm_clr, md_busy, md_err;
  logic [31:0] stall_cyc, flush_cnt;
  logic [7:0]  ctl;

  int n_cmp = 0;
  int n_err = 0;

`ifdef STALL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc_en, fd_en, fd_clr, dx_en, dx_clr, xm_en, xm_clr, md_busy}
  localparam logic [7:0] C_RST   = 8'b0010_1010;
  localparam logic [7:0] C_NORM  = 8'b1101_0100;
  localparam logic [7:0] C_LU    = 8'b0001_1100;
  localparam logic [7:0] C_REDIR = 8'b1111_1100;
  localparam logic [7:0] C_STALL = 8'b0000_0111;

  pipe_hazard_ctrl #(.MD_TIMEOUT(40), .CNT_W(6), .PERF_W(32)) dut (
    .clk(clk), .clr_n(clr_n), .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_uses_rt(fd_uses_rt),
    .dx_rd(dx_rd), .dx_is_load(dx_is_load), .x_redirect(x_redirect),
    .md_start(md_start), .md_ready(md_ready), .pc_en(pc_en), .fd_en(fd_en),
    .fd_clr(fd_clr), .dx_en(dx_en), .dx_clr(dx_clr), .xm_en(xm_en), .xm_clr(xm_clr),
    .md_busy(md_busy), .md_err(md_err), .stall_cyc(stall_cyc), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  assign ctl = {pc_en, fd_en, fd_clr, dx_en, dx_clr, xm_en, xm_clr, md_busy};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] perf(input logic [31:0] v);
    perf = PERF ? v : 32'd0;
  endfunction

  // Apply one cycle of inputs just after the edge; return mid-cycle for checking.
  task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                      input logic [4:0] rd, input logic ld, input logic redir,
                      input logic start, input logic ready);
    @(posedge clk);
    #1;
    fd_rs = rs; fd_rt = rt; fd_uses_rt = uses; dx_rd = rd; dx_is_load = ld;
    x_redirect = redir; md_start = start; md_ready = ready;
    #4;
  endtask

  initial begin
    clr_n = 1'b0;
    fd_rs = '0; fd_rt = '0; fd_uses_rt = 1'b0; dx_rd = '0; dx_is_load = 1'b0;
    x_redirect = 1'b0; md_start = 1'b0; md_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("reset_ctl", {24'd0, ctl}, {24'd0, C_RST});
    chk("reset_err", {31'd0, md_err}, 32'd0);
    chk("reset_stall_cyc", stall_cyc, 32'd0);
    #1 clr_n = 1'b1;

    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("normal", {24'd0, ctl}, {24'd0, C_NORM});
    step(5, 0, 0, 5, 1, 0, 0, 0);
    chk("load_use_rs", {24'd0, ctl}, {24'd0, C_LU});
    step(5, 0, 0, 0, 0, 0, 0, 0);
    chk("after_bubble", {24'd0, ctl}, {24'd0, C_NORM});
    step(0, 0, 0, 0, 1, 0, 0, 0);
    chk("load_rd0", {24'd0, ctl}, {24'd0, C_NORM});
    step(3, 7, 1, 7, 1, 0, 0, 0);
    chk("load_use_rt", {24'd0, ctl}, {24'd0, C_LU});
    step(3, 7, 0, 7, 1, 0, 0, 0);
    chk("rt_unused", {24'd0, ctl}, {24'd0, C_NORM});
    step(5, 0, 0, 5, 1, 1, 0, 0);
    chk("redirect_over_lu", {24'd0, ctl}, {24'd0, C_REDIR});

    // Mult/div: start at cycle 0, ready at cycle 5
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("md_c0", {24'd0, ctl}, {24'd0, C_STALL});
    for (int i = 1; i < 5; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("md_busy_cyc", {24'd0, ctl}, {24'd0, C_STALL});
    end
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("md_release", {24'd0, ctl}, {24'd0, C_NORM});
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("ready_idle_ignored", {24'd0, ctl}, {24'd0, C_NORM});
    chk("stall_cyc_md", stall_cyc, perf(32'd7));
    chk("flush_cnt_1", flush_cnt, perf(32'd1));
    chk("err_clean", {31'd0, md_err}, 32'd0);

    // Timeout: 1 IDLE stall + 39 BUSY stalls, release on the 40th BUSY cycle
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("to_c0", {24'd0, ctl}, {24'd0, C_STALL});
    for (int i = 0; i < 39; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("to_stall", {24'd0, ctl}, {24'd0, C_STALL});
    end
    chk("to_err_pre", {31'd0, md_err}, 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("to_release", {24'd0, ctl}, {24'd0, C_NORM});
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("to_idle", {24'd0, ctl}, {24'd0, C_NORM});
    chk("to_err", {31'd0, md_err}, 32'd1);
    chk("stall_cyc_to", stall_cyc, perf(32'd47));
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("to_err_sticky", {31'd0, md_err}, 32'd1);

    // Reset asserted while BUSY
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("busy_before_rst", {24'd0, ctl}, {24'd0, C_STALL});
    clr_n = 1'b0;
    #1;
    chk("rst_mid_busy_ctl", {24'd0, ctl}, {24'd0, C_RST});
    chk("rst_mid_busy_err", {31'd0, md_err}, 32'd0);
    chk("rst_stall_cyc", stall_cyc, 32'd0);
    @(posedge clk);
    #2 clr_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_idle", {24'd0, ctl}, {24'd0, C_NORM});

    // md_start together with x_redirect
    step(0, 0, 0, 0, 0, 1, 1, 0);
    chk("conflict_c0", {24'd0, ctl}, {24'd0, C_STALL});
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("conflict_busy", {24'd0, ctl}, {24'd0, C_STALL});
    chk("conflict_err", {31'd0, md_err}, 32'd1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("conflict_release", {24'd0, ctl}, {24'd0, C_NORM});
    step(0, 0, 0, 0, 0, 1, 0, 0);
    chk("redirect_plain", {24'd0, ctl}, {24'd0, C_REDIR});
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("flush_cnt_end", flush_cnt, perf(32'd1));
    chk("stall_cyc_end", stall_cyc, perf(32'd2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
